adder_sweep_ctrl: RTL



---
 rtl/adder_sweep_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/adder_sweep_ctrl.sv
// Self-checking sweep driver for a WIDTH-bit ripple adder: walks every {cin, a, b} vector,
// samples sum/cout after SETTLE cycles and counts mismatches. Define ADDER_SWEEP_LOG_EN for first-fail capture.
module adder_sweep_ctrl #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   a_o,
    output logic [WIDTH-1:0]   b_o,
    output logic               cin_o,
    input  logic [WIDTH-1:0]   sum_i,
    input  logic               cout_i,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count
`ifdef ADDER_SWEEP_LOG_EN
    ,
    output logic               first_fail_valid,
    output logic [2*WIDTH:0]   first_fail_vec
`endif
);

    localparam int VW = 2*WIDTH + 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]    SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;
    localparam logic [VW-1:0]    VEC_LAST    = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [VW-1:0]      vec_q, vec_d;
    logic [CW-1:0]      settle_q, settle_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    logic               accept;
    logic               mismatch;
    logic [WIDTH:0]     expected;

    // vec_q layout is {cin, a, b}, so incrementing it gives b inner, a middle, cin outer.
    always_comb begin
        expected = {1'b0, vec_q[VW-2 -: WIDTH]}
                 + {1'b0, vec_q[WIDTH-1:0]}
                 + {{WIDTH{1'b0}}, vec_q[VW-1]};
        mismatch = (expected != {cout_i, sum_i});
        accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        err_d    = err_q;
        pass_d   = pass_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d  = S_WAIT;
                    vec_d    = '0;
                    settle_d = '0;
                    err_d    = '0;
                    pass_d   = 1'b0;
                end
            end
            S_WAIT: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = S_CHECK;
                end else begin
                    settle_d = settle_q + CW'(1);
                end
            end
            S_CHECK: begin
                if (mismatch && (err_q != ERR_MAX)) begin
                    err_d = err_q + ERR_W'(1);
                end
                if (vec_q == VEC_LAST) begin
                    state_d = S_DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    vec_d   = vec_q + VW'(1);
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_WAIT) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

`ifdef ADDER_SWEEP_LOG_EN
    logic               ff_valid_q, ff_valid_d;
    logic [VW-1:0]      ff_vec_q, ff_vec_d;

    // Only the first mismatch of a sweep is recorded; later ones leave the log alone.
    always_comb begin
        ff_valid_d = ff_valid_q;
        ff_vec_d   = ff_vec_q;
        if (accept) begin
            ff_valid_d = 1'b0;
            ff_vec_d   = '0;
        end else if ((state_q == S_CHECK) && mismatch && !ff_valid_q) begin
            ff_valid_d = 1'b1;
            ff_vec_d   = vec_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ff_valid_q <= 1'b0;
            ff_vec_q   <= '0;
        end else begin
            ff_valid_q <= ff_valid_d;
            ff_vec_q   <= ff_vec_d;
        end
    end

    assign first_fail_valid = ff_valid_q;
    assign first_fail_vec   = ff_vec_q;
`else
    // No first-fail capture in this build.
`endif

    assign a_o       = vec_q[VW-2 -: WIDTH];
    assign b_o       = vec_q[WIDTH-1:0];
    assign cin_o     = vec_q[VW-1];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;

endmodule
